// File: rtl/shift_unit_multicycle.sv
// shift_unit_multicycle
//   Iterative shifter. Accepts one operand/amount/op per handshake, then resolves one bit of
//   the shift amount per cycle: stage k shifts by 2^k when amt[k] is set. The final value is
//   presented as a registered result with valid/ready flow control.
//
//   Ports
//     clk        rising-edge clock
//     rst_n      synchronous active-low reset
//     in_valid   upstream presents in/shamt/op
//     in_ready   unit can accept (IDLE only)
//     in         operand, N bits
//     shamt      shift amount, LOG2N bits
//     op         00 SLL, 01 SRL, 10 SRA, 11 ROL
//     out_valid  result valid (DONE only)
//     out_ready  downstream accepts result
//     out        registered result
//     zero       registered out == 0
//
//   Build option: define SHIFT_ZERO_FAST_EN to send shamt==0 operations straight from IDLE to
//   DONE. Without it, shamt==0 walks all LOG2N shift cycles and produces the same result.
module shift_unit_multicycle #(
    parameter int unsigned N = 32,
    localparam int unsigned LOG2N = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     in,
    input  logic [LOG2N-1:0] shamt,
    input  logic [1:0]       op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [N-1:0]     out,
    output logic             zero
);

    localparam logic [1:0] OpSll = 2'b00;
    localparam logic [1:0] OpSrl = 2'b01;
    localparam logic [1:0] OpSra = 2'b10;
    localparam logic [1:0] OpRol = 2'b11;

    localparam logic [LOG2N-1:0] LastStep = LOG2N'(LOG2N - 1);
    localparam logic [LOG2N:0]   StageOne = 1;

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StDone
    } state_e;

    state_e           state;
    logic [N-1:0]     acc;
    logic [LOG2N-1:0] amt;
    logic [LOG2N-1:0] step;
    logic [1:0]       opr;

    logic [LOG2N:0]   stage_amt;
    logic [2*N-1:0]   rol_wide;
    logic [N-1:0]     stage;

    assign in_ready  = (state == StIdle);
    assign out_valid = (state == StDone);

    // One stage of the shift network: shift by 2^step if that bit of the amount is set.
    always_comb begin
        stage_amt = '0;
        if (amt[step]) begin
            stage_amt = StageOne << step;
        end
        // Rotate taken from the upper half of the doubled word, so wrapped bits land low.
        rol_wide = {acc, acc} << stage_amt;
        stage    = acc;
        unique case (opr)
            OpSll: stage = acc << stage_amt;
            OpSrl: stage = acc >> stage_amt;
            OpSra: stage = $signed(acc) >>> stage_amt;
            OpRol: stage = rol_wide[2*N-1 -: N];
            default: stage = acc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= StIdle;
            step  <= '0;
            acc   <= '0;
            amt   <= '0;
            opr   <= OpSll;
            out   <= '0;
            zero  <= 1'b1;
        end else begin
            unique case (state)
                StIdle: begin
                    if (in_valid) begin
                        acc  <= in;
                        amt  <= shamt;
                        opr  <= op;
                        step <= '0;
`ifdef SHIFT_ZERO_FAST_EN
                        if (shamt == '0) begin
                            state <= StDone;
                            out   <= in;
                            zero  <= (in == '0);
                        end else begin
                            state <= StShift;
                        end
`else
                        state <= StShift;
`endif
                    end
                end
                StShift: begin
                    acc  <= stage;
                    step <= step + 1'b1;
                    if (step == LastStep) begin
                        state <= StDone;
                        out   <= stage;
                        zero  <= (stage == '0);
                    end
                end
                StDone: begin
                    // A new request seen in this cycle is not taken; it waits for IDLE.
                    if (out_ready) begin
                        state <= StIdle;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_shift_unit_multicycle.sv
module tb_shift_unit_multicycle;

    localparam int unsigned N     = 32;
    localparam int unsigned LOG2N = 5;
`ifdef SHIFT_ZERO_FAST_EN
    localparam bit Fast = 1'b1;
`else
    localparam bit Fast = 1'b0;
`endif

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [N-1:0]      din;
    logic [LOG2N-1:0]  shamt;
    logic [1:0]        op;
    logic              out_valid;
    logic              out_ready;
    logic [N-1:0]      dout;
    logic              zero;

    shift_unit_multicycle #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in        (din),
        .shamt     (shamt),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (dout),
        .zero      (zero)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Single-shot reference shift, built bit by bit from the definition of each op.
    function automatic logic [N-1:0] ref_shift(input logic [N-1:0] x, input int s,
                                               input logic [1:0] o);
        logic [N-1:0] r;
        r = '0;
        for (int i = 0; i < int'(N); i++) begin
            case (o)
                2'b00: r[i] = (i >= s) ? x[i-s] : 1'b0;
                2'b01: r[i] = (i + s < int'(N)) ? x[i+s] : 1'b0;
                2'b10: r[i] = (i + s < int'(N)) ? x[i+s] : x[N-1];
                default: r[i] = x[(i - s + int'(N)) % int'(N)];
            endcase
        end
        return r;
    endfunction

    // Behavioural model: 0 idle, 1 busy (counting down shift cycles), 2 holding a result.
    int           m_st = 0;
    int           m_cnt = 0;
    int           m_accepts = 0;
    bit           model_on = 1'b0;
    logic [N-1:0] m_pend = '0;
    logic [N-1:0] m_out = '0;
    logic         m_zero = 1'b1;
    logic [N-1:0] sb[$];

    initial begin
        logic [N-1:0] r;
        forever begin
            @(posedge clk);
            if (!rst_n) begin
                m_st = 0; m_cnt = 0; m_out = '0; m_zero = 1'b1;
                sb.delete();
                model_on = 1'b1;
            end else begin
                case (m_st)
                    0: if (in_valid) begin
                        r = ref_shift(din, int'(shamt), op);
                        m_accepts++;
                        sb.push_back(r);
                        if (Fast && shamt == 0) begin
                            m_st = 2; m_out = r; m_zero = (r == 0);
                        end else begin
                            m_st = 1; m_cnt = LOG2N; m_pend = r;
                        end
                    end
                    1: begin
                        m_cnt--;
                        if (m_cnt == 0) begin
                            m_st = 2; m_out = m_pend; m_zero = (m_pend == 0);
                        end
                    end
                    default: if (out_ready) m_st = 0;
                endcase
            end
        end
    end

    // Compare process: every cycle against the model, plus scoreboard on each retire.
    initial begin
        forever begin
            @(negedge clk);
            if (model_on) begin
                check("in_ready", 32'(in_ready), 32'(m_st == 0));
                check("out_valid", 32'(out_valid), 32'(m_st == 2));
                check("out", dout, m_out);
                check("zero", 32'(zero), 32'(m_zero));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) check("sb_unexpected_result", 32'd1, 32'd0);
                    else check("sb_result", dout, sb.pop_front());
                end
            end
        end
    end

    task automatic do_op(input string name, input logic [N-1:0] x, input logic [LOG2N-1:0] s,
                         input logic [1:0] o, input logic [N-1:0] exp, input bit retire);
        int w;
        int lat;
        int exp_lat;
        w = 0;
        while (!in_ready && w < 20) begin
            @(posedge clk); #1; w++;
        end
        check({name, "_ready"}, 32'(in_ready), 32'd1);
        din = x; shamt = s; op = o; in_valid = 1'b1;
        @(posedge clk); #1;
        // Scramble the inputs after accept; they must not matter.
        in_valid = 1'b0; din = $urandom; shamt = 5'($urandom); op = 2'($urandom);
        lat = 0;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1; lat++;
        end
        // Edges after the accept edge until out_valid is visible (fast path: same edge).
        exp_lat = (Fast && s == 0) ? 0 : int'(LOG2N);
        check({name, "_latency"}, 32'(lat), 32'(exp_lat));
        check({name, "_out"}, dout, exp);
        check({name, "_zero"}, 32'(zero), 32'(exp == 0));
        if (retire) begin
            out_ready = 1'b1;
            @(posedge clk); #1;
            out_ready = 1'b0;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        int start;
        logic [N-1:0] held;

        rst_n = 1'b0; in_valid = 1'b0; din = '0; shamt = '0; op = '0; out_ready = 1'b0;

        // Pin the reference model to hand-computed values.
        check("ref_sll31", ref_shift(32'h0000_0001, 31, 2'b00), 32'h8000_0000);
        check("ref_sra4", ref_shift(32'h8000_0000, 4, 2'b10), 32'hF800_0000);
        check("ref_srl4", ref_shift(32'h8000_0000, 4, 2'b01), 32'h0800_0000);
        check("ref_rol1", ref_shift(32'h8000_0001, 1, 2'b11), 32'h0000_0003);
        check("ref_rol8", ref_shift(32'h1234_5678, 8, 2'b11), 32'h3456_7812);
        check("ref_sra0", ref_shift(32'hDEAD_BEEF, 0, 2'b10), 32'hDEAD_BEEF);

        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out", dout, 32'd0);
        check("reset_zero", 32'(zero), 32'd1);

        do_op("sll31", 32'h0000_0001, 5'd31, 2'b00, 32'h8000_0000, 1'b1);
        do_op("sra4", 32'h8000_0000, 5'd4, 2'b10, 32'hF800_0000, 1'b1);
        do_op("srl4", 32'h8000_0000, 5'd4, 2'b01, 32'h0800_0000, 1'b1);
        do_op("sll1_zero", 32'h8000_0000, 5'd1, 2'b00, 32'h0000_0000, 1'b1);
        do_op("rol1", 32'h8000_0001, 5'd1, 2'b11, 32'h0000_0003, 1'b1);
        do_op("rol8", 32'h1234_5678, 5'd8, 2'b11, 32'h3456_7812, 1'b1);
        do_op("sra0", 32'hDEAD_BEEF, 5'd0, 2'b10, 32'hDEAD_BEEF, 1'b1);

        // Back-pressure: result held, new requests ignored.
        do_op("hold", 32'h0000_00F0, 5'd4, 2'b00, 32'h0000_0F00, 1'b0);
        held = dout;
        in_valid = 1'b1; din = 32'h5555_5555; shamt = 5'd3; op = 2'b01;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("hold_out", dout, held);
            check("hold_valid", 32'(out_valid), 32'd1);
            check("hold_in_ready", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check("retire_valid", 32'(out_valid), 32'd0);
        check("retire_in_ready", 32'(in_ready), 32'd1);
        check("retire_out_kept", dout, held);
        in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;

        // Reset in the middle of the shift sequence.
        din = 32'h1234_5678; shamt = 5'd7; op = 2'b00; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("midreset_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out", dout, 32'd0);
        check("midreset_zero", 32'(zero), 32'd1);
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            check("midreset_no_stale", 32'(out_valid), 32'd0);
        end

        // Randomized traffic against the model and scoreboard.
        cyc = 0;
        start = m_accepts;
        while (m_accepts - start < 1000 && cyc < 30000) begin
            in_valid = ($urandom % 10) < 7;
            din = $urandom;
            if ($urandom % 4 == 0) shamt = ($urandom % 2 == 0) ? 5'd0 : 5'd31;
            else shamt = 5'($urandom);
            op = 2'($urandom);
            out_ready = 1'($urandom);
            @(posedge clk); #1;
            cyc++;
        end
        check("random_ops_done", 32'(m_accepts - start >= 1000), 32'd1);
        in_valid = 1'b0;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_idle", 32'(in_ready), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
